// File: rtl/sweep_pkg.sv
// Shared definitions for the sweep clock domain: data widths, the binning
// state machine encoding and the closed-bin record.
package sweep_pkg;

  localparam int SAMPLE_W = 12;
  localparam int CNT_W    = 13;
  localparam int SUM_W    = SAMPLE_W + CNT_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    ACCUM = 2'd2
  } state_e;

  typedef struct packed {
    logic [SAMPLE_W-1:0] vc;
    logic [SUM_W-1:0]    sum;
    logic [CNT_W-1:0]    count;
    logic                sat;
  } bin_t;

endpackage

// File: rtl/step_averager_out_reg1.sv
// Generic 1-entry valid/ready holding register. A new word may load whenever
// the register is empty or its current word is being accepted this cycle.
module out_reg1 #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  assign o_ready = !valid_q || i_ready;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (i_valid && o_ready) begin
      valid_d = 1'b1;
      data_d  = i_data;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the payload register is reset as well; it drives module outputs
  // directly and must read 0 after reset, not stale data from before it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;

endmodule

// File: rtl/step_averager.sv
// Bins ADC samples per sweep step: sums every valid sample while the DAC
// holds one voltage and offers each closed bin through a 1-entry register.
module step_averager #(
  parameter int SAMPLE_W = sweep_pkg::SAMPLE_W,
  parameter int CNT_W    = sweep_pkg::CNT_W,
  parameter int SUM_W    = SAMPLE_W + CNT_W
) (
  input  logic                i_stepCLK,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic [SAMPLE_W-1:0] i_vc,
  input  logic                i_stepping,
  input  logic [SAMPLE_W-1:0] i_sample,
  input  logic                i_sample_valid,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SAMPLE_W-1:0] o_vc,
  output logic [SUM_W-1:0]    o_sum,
  output logic [CNT_W-1:0]    o_count,
  output logic                o_sat,
  output logic                o_overrun,
  output logic [7:0]          o_dropped
);

  import sweep_pkg::*;

  localparam int               PAYLOAD_W = SAMPLE_W + SUM_W + CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_e              state_q, state_d;
  logic [SAMPLE_W-1:0] vc_q, vc_d;
  logic [SUM_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sat_q, sat_d;
  logic                overrun_q, overrun_d;
  logic [7:0]          dropped_q, dropped_d;

  logic                 start_bin;
  logic                 close_bin;
  logic                 out_can_load;
  logic [PAYLOAD_W-1:0] close_payload;
  logic [PAYLOAD_W-1:0] out_payload;

  // A step in ARM only aligns the first bin; only a step in ACCUM closes one.
  assign start_bin = i_enable && i_stepping && (state_q == ARM || state_q == ACCUM);
  assign close_bin = i_enable && i_stepping && (state_q == ACCUM);

  // The closing bin is taken from the registers before this cycle's restart.
  assign close_payload = {vc_q, acc_q, cnt_q, sat_q};

  always_comb begin
    state_d   = state_q;
    vc_d      = vc_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sat_d     = sat_q;
    overrun_d = overrun_q;
    dropped_d = dropped_q;

    if (!i_enable) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      sat_d   = 1'b0;
    end else if (start_bin) begin
      state_d = ACCUM;
      vc_d    = i_vc;
      acc_d   = i_sample_valid ? SUM_W'(i_sample) : '0;
      cnt_d   = i_sample_valid ? CNT_W'(1) : '0;
      sat_d   = 1'b0;
    end else if (state_q == IDLE) begin
      state_d = ARM;
    end else if (state_q == ACCUM && i_sample_valid) begin
      if (cnt_q != CNT_MAX) begin
        acc_d = acc_q + SUM_W'(i_sample);
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        sat_d = 1'b1;
      end
    end

    if (close_bin && !out_can_load) begin
      overrun_d = 1'b1;
      if (dropped_q != 8'hFF) begin
        dropped_d = dropped_q + 8'd1;
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // values from before the clock edge regardless of statement order.
  always_ff @(posedge i_stepCLK) begin
    if (i_reset) begin
      state_q   <= IDLE;
      vc_q      <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
      overrun_q <= 1'b0;
      dropped_q <= '0;
    end else begin
      state_q   <= state_d;
      vc_q      <= vc_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
      overrun_q <= overrun_d;
      dropped_q <= dropped_d;
    end
  end

  out_reg1 #(
    .W(PAYLOAD_W)
  ) u_out_reg (
    .i_clk   (i_stepCLK),
    .i_reset (i_reset),
    .i_valid (close_bin),
    .o_ready (out_can_load),
    .i_data  (close_payload),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (out_payload)
  );

  assign {o_vc, o_sum, o_count, o_sat} = out_payload;
  assign o_overrun = overrun_q;
  assign o_dropped = dropped_q;

endmodule

// File: tb/tb_step_averager.sv
// Bench for step_averager: a bin-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_step_averager;

  import sweep_pkg::*;

  localparam int MAX_CNT = 8191;

  logic                clk = 1'b0;
  logic                i_reset = 1'b1;
  logic                i_enable = 1'b0;
  logic [SAMPLE_W-1:0] i_vc = '0;
  logic                i_stepping = 1'b0;
  logic [SAMPLE_W-1:0] i_sample = '0;
  logic                i_sample_valid = 1'b0;
  logic                i_ready = 1'b0;
  logic                o_valid;
  logic [SAMPLE_W-1:0] o_vc;
  logic [SUM_W-1:0]    o_sum;
  logic [CNT_W-1:0]    o_count;
  logic                o_sat;
  logic                o_overrun;
  logic [7:0]          o_dropped;

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  step_averager dut (
    .i_stepCLK      (clk),
    .i_reset        (i_reset),
    .i_enable       (i_enable),
    .i_vc           (i_vc),
    .i_stepping     (i_stepping),
    .i_sample       (i_sample),
    .i_sample_valid (i_sample_valid),
    .o_valid        (o_valid),
    .i_ready        (i_ready),
    .o_vc           (o_vc),
    .o_sum          (o_sum),
    .o_count        (o_count),
    .o_sat          (o_sat),
    .o_overrun      (o_overrun),
    .o_dropped      (o_dropped)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: the binner is off, waiting for an aligning step, or
  // collecting a bin; a bin is the list of samples seen since its step.
  typedef enum int { M_OFF, M_WAITING, M_BINNING } mode_e;

  mode_e m_mode      = M_OFF;
  int    m_n         = 0;
  int    m_sum       = 0;
  int    m_vc        = 0;
  bit    m_out_valid = 1'b0;
  bin_t  m_out       = '0;
  bit    m_overrun   = 1'b0;
  int    m_dropped   = 0;
  bit    m_accept;
  bit    m_closed;
  bin_t  m_closed_bin;

  task automatic model_add(input int smp);
    m_n++;
    if (m_n <= MAX_CNT) m_sum += smp;
  endtask

  always @(posedge clk) begin
    if (i_reset) begin
      m_mode = M_OFF; m_n = 0; m_sum = 0; m_vc = 0;
      m_out_valid = 1'b0; m_out = '0; m_overrun = 1'b0; m_dropped = 0;
    end else begin
      m_accept = m_out_valid && i_ready;
      m_closed = 1'b0;
      if (!i_enable) begin
        m_mode = M_OFF;
      end else if (m_mode == M_OFF) begin
        m_mode = M_WAITING;
      end else if (i_stepping) begin
        if (m_mode == M_BINNING) begin
          m_closed           = 1'b1;
          m_closed_bin.vc    = SAMPLE_W'(m_vc);
          m_closed_bin.sum   = SUM_W'(m_sum);
          m_closed_bin.count = CNT_W'((m_n > MAX_CNT) ? MAX_CNT : m_n);
          m_closed_bin.sat   = (m_n > MAX_CNT);
        end
        m_mode = M_BINNING;
        m_vc   = int'(i_vc);
        m_n    = 0;
        m_sum  = 0;
        if (i_sample_valid) model_add(int'(i_sample));
      end else if (m_mode == M_BINNING && i_sample_valid) begin
        model_add(int'(i_sample));
      end

      if (m_closed) begin
        if (!m_out_valid || m_accept) begin
          m_out       = m_closed_bin;
          m_out_valid = 1'b1;
        end else begin
          m_overrun = 1'b1;
          if (m_dropped < 255) m_dropped++;
        end
      end else if (m_accept) begin
        m_out_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cyc_valid", 32'(o_valid), 32'(m_out_valid));
      check("cyc_overrun", 32'(o_overrun), 32'(m_overrun));
      check("cyc_dropped", 32'(o_dropped), 32'(m_dropped));
      if (m_out_valid) begin
        check("cyc_vc", 32'(o_vc), 32'(m_out.vc));
        check("cyc_sum", 32'(o_sum), 32'(m_out.sum));
        check("cyc_count", 32'(o_count), 32'(m_out.count));
        check("cyc_sat", 32'(o_sat), 32'(m_out.sat));
      end
    end
  end

  // Apply one cycle of inputs; returns 1 time unit after the capturing edge.
  task automatic cyc(input bit rst, input bit en, input bit stp, input int vc,
                     input bit sv, input int smp, input bit rdy);
    i_reset        = rst;
    i_enable       = en;
    i_stepping     = stp;
    i_vc           = SAMPLE_W'(vc);
    i_sample_valid = sv;
    i_sample       = SAMPLE_W'(smp);
    i_ready        = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk_on = 1'b1;
    check("rst_valid", 32'(o_valid), 0);
    check("rst_overrun", 32'(o_overrun), 0);
    check("rst_dropped", 32'(o_dropped), 0);
    check("rst_sum", 32'(o_sum), 0);

    // Unaligned samples before the first step are never emitted.
    for (int k = 0; k < 10; k++) cyc(0, 1, 0, 0, 1, 100, 1);
    check("arm_no_valid", 32'(o_valid), 0);

    // Basic bin: 5 on the step cycle plus three 7s.
    cyc(0, 1, 1, 'h200, 1, 5, 1);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 1, 7, 1);
    check("bin1_not_yet", 32'(o_valid), 0);
    cyc(0, 1, 1, 'h210, 0, 0, 1);
    check("bin1_valid", 32'(o_valid), 1);
    check("bin1_vc", 32'(o_vc), 'h200);
    check("bin1_sum", 32'(o_sum), 26);
    check("bin1_count", 32'(o_count), 4);
    check("bin1_sat", 32'(o_sat), 0);
    check("bin1_model_sum", 32'(m_out.sum), 26);
    cyc(0, 1, 0, 0, 0, 0, 1);
    check("bin1_one_beat", 32'(o_valid), 0);

    // Empty bin between two consecutive steps.
    cyc(0, 1, 1, 'h220, 0, 0, 1);
    check("empty_valid", 32'(o_valid), 1);
    check("empty_vc", 32'(o_vc), 'h210);
    check("empty_count", 32'(o_count), 0);
    check("empty_sum", 32'(o_sum), 0);
    cyc(0, 1, 0, 0, 0, 0, 1);

    // Backpressure: re-arm, then three steps with the consumer stalled.
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 'h300, 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 0, 0, 1, 1, 0);
    cyc(0, 1, 1, 'h301, 0, 0, 0);
    cyc(0, 1, 1, 'h302, 0, 0, 0);
    check("bp_held_vc", 32'(o_vc), 'h300);
    check("bp_held_sum", 32'(o_sum), 3);
    check("bp_overrun", 32'(o_overrun), 1);
    check("bp_dropped", 32'(o_dropped), 1);
    check("bp_model_dropped", 32'(m_dropped), 1);
    cyc(0, 1, 0, 0, 0, 0, 1);
    check("bp_drained", 32'(o_valid), 0);

    // Count saturation: 8192 full-scale samples in one bin.
    cyc(0, 1, 1, 'h400, 1, 'hFFF, 1);
    for (int k = 0; k < 8191; k++) cyc(0, 1, 0, 0, 1, 'hFFF, 1);
    cyc(0, 1, 1, 'h401, 0, 0, 1);
    check("sat_count", 32'(o_count), 8191);
    check("sat_sum", 32'(o_sum), 32'd33542145);
    check("sat_flag", 32'(o_sat), 1);
    check("sat_model_count", 32'(m_out.count), 8191);

    // Disable mid-bin discards the partial; re-armed bin has only new samples.
    cyc(0, 1, 0, 0, 1, 50, 1);
    cyc(0, 1, 0, 0, 1, 50, 1);
    cyc(0, 0, 0, 0, 1, 50, 1);
    cyc(0, 1, 0, 0, 1, 9, 1);
    cyc(0, 1, 0, 0, 1, 9, 1);
    cyc(0, 1, 1, 'h500, 1, 11, 1);
    check("reen_no_partial", 32'(o_valid), 0);
    cyc(0, 1, 0, 0, 1, 4, 1);
    cyc(0, 1, 0, 0, 1, 4, 1);
    cyc(0, 1, 1, 'h501, 0, 0, 1);
    check("reen_vc", 32'(o_vc), 'h500);
    check("reen_sum", 32'(o_sum), 19);
    check("reen_count", 32'(o_count), 3);
    cyc(0, 1, 0, 0, 1, 3, 0);
    cyc(0, 1, 0, 0, 1, 3, 0);
    check("pre_rst_valid", 32'(o_valid), 1);
    cyc(1, 1, 0, 0, 1, 3, 0);
    check("midrst_valid", 32'(o_valid), 0);
    check("midrst_overrun", 32'(o_overrun), 0);
    check("midrst_dropped", 32'(o_dropped), 0);
    check("midrst_vc", 32'(o_vc), 0);
    check("midrst_count", 32'(o_count), 0);

    // Dropped counter saturates at 255.
    cyc(0, 1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 300; k++) cyc(0, 1, 1, k, 1, k, 0);
    check("drop_sat", 32'(o_dropped), 255);
    check("drop_overrun", 32'(o_overrun), 1);

    // Randomized traffic against the model.
    cyc(1, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < 4000; k++) begin
      cyc(($urandom_range(0, 499) == 0),
          ($urandom_range(0, 59) != 0),
          ($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 4095)),
          bit'($urandom_range(0, 1)),
          int'($urandom_range(0, 4095)),
          ($urandom_range(0, 2) != 0));
    end

    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
